// File: rtl/pll_clkdiv_pkg.sv
// Shared types and constants for the PLL-fed programmable clock divider.
// The optional period monitor is enabled with PLL_CLKDIV_MONITOR_EN.
package pll_clkdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_e;

    localparam int MIN_DIV       = 2;
    localparam int DEFAULT_DIV_W = 5;
    localparam int STABLE_CNT_W  = 8;

    // Ratios below MIN_DIV cannot form a high and a low phase, so they are promoted.
    function automatic int unsigned eff_ratio(input int unsigned n);
        return (n < MIN_DIV) ? MIN_DIV : n;
    endfunction

endpackage

// File: rtl/pll_sync2.sv
// Parameterised-width two-flop synchroniser with asynchronous active-low reset.
module pll_sync2 #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] stage1_q;
    logic [W-1:0] stage2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage1_q <= '0;
            stage2_q <= '0;
        end else begin
            stage1_q <= d_i;
            stage2_q <= stage1_q;
        end
    end

    assign q_o = stage2_q;

endmodule

// File: rtl/pll_clock_divider.sv
// Glitch-free programmable divider for the PLL output clock; ratio and enable are sampled only at period boundaries.
// Define PLL_CLKDIV_MONITOR_EN to add the period_count output.
module pll_clock_divider
    import pll_clkdiv_pkg::*;
#(
    parameter int DIV_W          = DEFAULT_DIV_W,
    parameter int STABLE_PERIODS = 8
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic             enable,
    input  logic [DIV_W-1:0] div_in,
    output logic             clk_out,
    output logic             stable,
    output logic             update_pulse
`ifdef PLL_CLKDIV_MONITOR_EN
    ,
    output logic [15:0]      period_count
`endif
);

    logic             enable_s;
    logic [DIV_W-1:0] div_s;

    pll_sync2 #(.W(1)) u_sync_enable (
        .clk_i  (clock),
        .rst_ni (resetb),
        .d_i    (enable),
        .q_o    (enable_s)
    );

    pll_sync2 #(.W(DIV_W)) u_sync_div (
        .clk_i  (clock),
        .rst_ni (resetb),
        .d_i    (div_in),
        .q_o    (div_s)
    );

    state_e                  state_q, state_d;
    logic [DIV_W-1:0]        cnt_q, cnt_d;
    logic [DIV_W-1:0]        div_act_q, div_act_d;
    logic [STABLE_CNT_W-1:0] stable_cnt_q, stable_cnt_d;
    logic                    clk_out_q, clk_out_d;
    logic                    stable_q, stable_d;
    logic                    update_pulse_q, update_pulse_d;

    logic [DIV_W-1:0] neff;
    logic [DIV_W-1:0] high_last;
    logic [DIV_W-1:0] low_last;
    logic             load;
    logic             period_done;
    logic             stable_clr;

    // Odd ratios put the extra cycle in the high phase.
    assign neff      = DIV_W'(eff_ratio(32'(div_act_q)));
    assign high_last = (neff - (neff >> 1)) - DIV_W'(1);
    assign low_last  = (neff >> 1) - DIV_W'(1);

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            div_act_q      <= '0;
            stable_cnt_q   <= '0;
            clk_out_q      <= 1'b0;
            stable_q       <= 1'b0;
            update_pulse_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            div_act_q      <= div_act_d;
            stable_cnt_q   <= stable_cnt_d;
            clk_out_q      <= clk_out_d;
            stable_q       <= stable_d;
            update_pulse_q <= update_pulse_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        div_act_d    = div_act_q;
        stable_cnt_d = stable_cnt_q;
        load         = 1'b0;
        period_done  = 1'b0;
        stable_clr   = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable_s) begin
                    div_act_d = div_s;
                    cnt_d     = '0;
                    load      = 1'b1;
                    state_d   = HIGH;
                end
            end
            HIGH: begin
                if (cnt_q == high_last) begin
                    cnt_d   = '0;
                    state_d = LOW;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            LOW: begin
                if (cnt_q == low_last) begin
                    cnt_d       = '0;
                    period_done = 1'b1;
                    // Enable drop takes priority over a pending ratio change.
                    if (!enable_s) begin
                        stable_cnt_d = '0;
                        stable_clr   = 1'b1;
                        state_d      = IDLE;
                    end else if (div_s != div_act_q) begin
                        div_act_d    = div_s;
                        load         = 1'b1;
                        stable_cnt_d = '0;
                        stable_clr   = 1'b1;
                        state_d      = HIGH;
                    end else begin
                        if (stable_cnt_q != '1) begin
                            stable_cnt_d = stable_cnt_q + STABLE_CNT_W'(1);
                        end
                        state_d = HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        clk_out_d      = (state_d == HIGH);
        update_pulse_d = load;
        stable_d       = stable_clr ? 1'b0
                                    : (stable_cnt_q >= STABLE_CNT_W'(STABLE_PERIODS));
    end

    assign clk_out      = clk_out_q;
    assign stable       = stable_q;
    assign update_pulse = update_pulse_q;

`ifdef PLL_CLKDIV_MONITOR_EN
    logic [15:0] period_count_q;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            period_count_q <= '0;
        end else if (load || (period_done && !enable_s)) begin
            period_count_q <= '0;
        end else if (period_done && (period_count_q != 16'hFFFF)) begin
            period_count_q <= period_count_q + 16'd1;
        end
    end

    assign period_count = period_count_q;
`endif

endmodule

// File: tb/tb_pll_clock_divider.sv
// Directed, table-driven bench for pll_clock_divider: ratio shapes, startup, ratio change, enable drop, async reset.
module tb_pll_clock_divider;

    logic        clock = 1'b0;
    logic        resetb;
    logic        enable;
    logic [4:0]  div_in;
    logic        clk_out;
    logic        stable;
    logic        update_pulse;
`ifdef PLL_CLKDIV_MONITOR_EN
    logic [15:0] period_count;
`endif

    int checkCount = 0;
    int passCount  = 0;

    pll_clock_divider #(.DIV_W(5), .STABLE_PERIODS(8)) dut (
        .clock        (clock),
        .resetb       (resetb),
        .enable       (enable),
        .div_in       (div_in),
        .clk_out      (clk_out),
        .stable       (stable),
        .update_pulse (update_pulse)
`ifdef PLL_CLKDIV_MONITOR_EN
        ,
        .period_count (period_count)
`endif
    );

    always #5 clock = ~clock;

    // Tracks the width of the most recent completed high pulse on clk_out.
    int runLen   = 0;
    int lastHigh = 0;
    always @(negedge clock) begin
        if (clk_out) begin
            runLen <= runLen + 1;
        end else begin
            if (runLen != 0) lastHigh <= runLen;
            runLen <= 0;
        end
    end

    typedef struct {
        logic [4:0] div;
        int         expHigh;
        int         expLow;
    } vec_t;

    vec_t vecs[10];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [4:0] div);
        enable = en;
        div_in = div;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    // Holds reset, then releases it on a falling edge with the requested ratio already enabled.
    task automatic startDivider(input logic [4:0] div);
        resetb = 1'b0;
        applyStimulus(1'b0, 5'd0);
        repeat (2) @(negedge clock);
        applyStimulus(1'b1, div);
        resetb = 1'b1;
    endtask

    task automatic measurePeriod(output int hi, output int lo);
        hi = 0;
        lo = 0;
        while (clk_out && hi < 64) begin
            hi++;
            step(1);
        end
        while (!clk_out && lo < 64) begin
            lo++;
            step(1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int hi, lo, waited;
        bit [4:0] expSeq;

        vecs[0] = '{5'd4,  2,  2};
        vecs[1] = '{5'd5,  3,  2};
        vecs[2] = '{5'd0,  1,  1};
        vecs[3] = '{5'd1,  1,  1};
        vecs[4] = '{5'd2,  1,  1};
        vecs[5] = '{5'd3,  2,  1};
        vecs[6] = '{5'd6,  3,  3};
        vecs[7] = '{5'd7,  4,  3};
        vecs[8] = '{5'd8,  4,  4};
        vecs[9] = '{5'd31, 16, 15};

        resetb = 1'b0;
        applyStimulus(1'b0, 5'd0);
        repeat (3) @(negedge clock);
        checkOutput("reset_clk_out", int'(clk_out), 0);
        checkOutput("reset_stable", int'(stable), 0);
        checkOutput("reset_update_pulse", int'(update_pulse), 0);

        $display("[TB] startup sequence at ratio 4");
        startDivider(5'd4);
        step(2);
        checkOutput("startup_clk_low_edge2", int'(clk_out), 0);
        checkOutput("startup_no_pulse_edge2", int'(update_pulse), 0);
        step(1);
        checkOutput("startup_clk_high_edge3", int'(clk_out), 1);
        checkOutput("startup_pulse_edge3", int'(update_pulse), 1);
        step(1);
        checkOutput("startup_pulse_cleared", int'(update_pulse), 0);
        step(31);
        checkOutput("stable_low_edge35", int'(stable), 0);
        step(1);
        checkOutput("stable_high_edge36", int'(stable), 1);

        $display("[TB] ratio shape table");
        foreach (vecs[i]) begin
            startDivider(vecs[i].div);
            step(3);
            checkOutput($sformatf("shape_first_high_div%0d", vecs[i].div), int'(clk_out), 1);
            measurePeriod(hi, lo);
            checkOutput($sformatf("shape_high_div%0d", vecs[i].div), hi, vecs[i].expHigh);
            checkOutput($sformatf("shape_low_div%0d", vecs[i].div), lo, vecs[i].expLow);
        end

        $display("[TB] ratio change 6 -> 3 mid-high");
        startDivider(5'd6);
        step(51);
        checkOutput("chg_stable_low_edge51", int'(stable), 0);
        step(1);
        checkOutput("chg_stable_high_edge52", int'(stable), 1);
        applyStimulus(1'b1, 5'd3);
        step(1);
        checkOutput("chg_old_high_edge53", int'(clk_out), 1);
        step(1);
        checkOutput("chg_old_low_edge54", int'(clk_out), 0);
        step(2);
        checkOutput("chg_old_low_edge56", int'(clk_out), 0);
        checkOutput("chg_no_pulse_edge56", int'(update_pulse), 0);
        step(1);
        checkOutput("chg_new_high_edge57", int'(clk_out), 1);
        checkOutput("chg_pulse_edge57", int'(update_pulse), 1);
        checkOutput("chg_stable_drop_edge57", int'(stable), 0);
        step(1);
        checkOutput("chg_high_edge58", int'(clk_out), 1);
        checkOutput("chg_pulse_cleared_edge58", int'(update_pulse), 0);
        step(1);
        checkOutput("chg_low_edge59", int'(clk_out), 0);
        step(1);
        checkOutput("chg_high_edge60", int'(clk_out), 1);
        step(21);
        checkOutput("chg_stable_low_edge81", int'(stable), 0);
        step(1);
        checkOutput("chg_stable_high_edge82", int'(stable), 1);

        $display("[TB] enable drop with simultaneous ratio change at ratio 8");
        startDivider(5'd8);
        step(3);
        checkOutput("drop_high_edge3", int'(clk_out), 1);
        applyStimulus(1'b0, 5'd3);
        expSeq = 5'b0;
        for (int e = 4; e <= 10; e++) begin
            step(1);
            checkOutput($sformatf("drop_period_edge%0d", e), int'(clk_out), (e <= 6) ? 1 : 0);
        end
        step(1);
        checkOutput("drop_idle_edge11", int'(clk_out), 0);
        checkOutput("drop_no_pulse_edge11", int'(update_pulse), 0);
        step(9);
        checkOutput("drop_idle_edge20", int'(clk_out), 0);
        checkOutput("drop_stable_edge20", int'(stable), 0);
        checkOutput("drop_last_pulse_width", lastHigh, 4);

        $display("[TB] asynchronous reset mid-high at ratio 7");
        startDivider(5'd7);
        step(4);
        checkOutput("areset_high_before", int'(clk_out), 1);
        #1 resetb = 1'b0;
        #1;
        checkOutput("areset_clk_immediate", int'(clk_out), 0);
        @(negedge clock);
        resetb = 1'b1;
        step(2);
        checkOutput("areset_restart_low_edge2", int'(clk_out), 0);
        step(1);
        checkOutput("areset_restart_high_edge3", int'(clk_out), 1);
        checkOutput("areset_restart_pulse", int'(update_pulse), 1);

`ifdef PLL_CLKDIV_MONITOR_EN
        $display("[TB] period monitor at ratio 2");
        startDivider(5'd2);
        step(203);
        checkOutput("mon_count_100", int'(period_count), 100);
        applyStimulus(1'b1, 5'd3);
        waited = 0;
        while (!update_pulse && waited < 20) begin
            step(1);
            waited++;
        end
        checkOutput("mon_update_seen", int'(update_pulse), 1);
        checkOutput("mon_cleared", int'(period_count), 0);
`else
        waited = 0;
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
